uart_cmd_rx: RTL

Oversampled UART receiver and command-hold stage sitting directly upstream of the controller-byte parser. It turns the asynchronous serial line from the wireless controller into validated bytes. It also keeps a held command byte that the parser decodes into right/left/jump/squat/attack/defend/select. If the controller link goes silent, the held byte clears to 0x00 so no button stays stuck.

---
 rtl/uart_cmd_rx.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: oversampled UART receiver with a held command byte.
// Receives 8N1 frames (or 8E1 when UART_RX_PARITY_EN is defined), majority-votes
// three mid-bit samples, and keeps the last good byte on o_cmd until the link
// has been silent for HOLD_CYCLES clocks, after which o_cmd clears to 0x00.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 28,
  parameter int HOLD_CYCLES  = 322560
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy,
  output logic [7:0] o_cmd
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SAMP0  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_SAMP1  = CW'(HALF);
  localparam logic [CW-1:0] CNT_DECIDE = CW'(HALF + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE   = HW'(HOLD_CYCLES - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;
`endif

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt;
  logic            r_samp0;
  logic            r_samp1;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitIdx;
  logic            r_bad;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frameErr;
  logic            r_busy;
  logic [7:0]      r_cmd;
  logic [HW-1:0]   r_holdCnt;
`ifdef UART_RX_PARITY_EN
  logic            r_parityErr;
`endif

  logic            w_rxS;
  logic            w_decide;
  logic            w_bit;
  logic            w_goodFrame;

  // Two-flop synchronizer; both stages reset high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  assign w_rxS    = r_sync[1];
  assign w_decide = (r_cnt == CNT_DECIDE);

  // 2-of-3 vote over the samples at HALF-1, HALF and the live sample at HALF+1.
  assign w_bit = (r_samp0 & r_samp1) | (r_samp0 & w_rxS) | (r_samp1 & w_rxS);

  // A clean stop bit on an unflagged frame is the only thing that updates the command.
  assign w_goodFrame = (r_state == S_STOP) && w_decide && w_bit && !r_bad;

  // Receive FSM with bit timing, sample capture and registered pulse outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_samp0    <= 1'b0;
      r_samp1    <= 1'b0;
      r_shift    <= 8'h00;
      r_bitIdx   <= 3'd0;
      r_bad      <= 1'b0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif

      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (r_cnt == CNT_SAMP0) begin
        r_samp0 <= w_rxS;
      end
      if (r_cnt == CNT_SAMP1) begin
        r_samp1 <= w_rxS;
      end

      case (r_state)
        S_IDLE: begin
          r_bad    <= 1'b0;
          r_bitIdx <= 3'd0;
          if (!w_rxS) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_decide) begin
            if (w_bit) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_decide) begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_decide) begin
            if (w_bit != (^r_shift)) begin
              r_parityErr <= 1'b1;
              r_bad       <= 1'b1;
            end
            r_state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (w_decide) begin
            if (w_bit) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              if (!r_bad) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
              end
            end else begin
              r_frameErr <= 1'b1;
              r_state    <= S_WAIT_HIGH;
            end
          end
        end

        S_WAIT_HIGH: begin
          if (w_rxS) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Command hold: a good frame reloads the byte and restarts the silence timer,
  // which saturates at HOLD_CYCLES and clears the command on the cycle it gets there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd     <= 8'h00;
      r_holdCnt <= '0;
    end else if (w_goodFrame) begin
      r_cmd     <= r_shift;
      r_holdCnt <= '0;
    end else if (r_holdCnt != HOLD_MAX) begin
      r_holdCnt <= r_holdCnt + HW'(1);
      if (r_holdCnt == HOLD_PRE) begin
        r_cmd <= 8'h00;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frameErr;
  assign o_busy      = r_busy;
  assign o_cmd       = r_cmd;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parityErr;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
